// File: rtl/p_cdc_pkg.sv
// Shared types and default sizing for the req/ack CDC transmitter.
// No logic; no latency; no backpressure.
// Pointer width is derived from the default depth.
package p_cdc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam int WIDTH_DFLT   = 8;
   localparam int DEPTH_DFLT   = 4;
   localparam int TIMEOUT_DFLT = 255;
   localparam int PTR_W        = $clog2(DEPTH_DFLT);

endpackage

// File: rtl/p_SSYNC3DO_C_PPP.sv
// Three-flop level synchronizer with asynchronous active-low clear to 0.
// Latency: 3 clk edges from d to q.
// No backpressure.
module p_SSYNC3DO_C_PPP (
   input  logic clk,
   input  logic clr_,
   input  logic d,
   output logic q
);

   logic [2:0] sync;

   always_ff @(posedge clk or negedge clr_) begin
      if (!clr_) begin
         sync <= 3'b000;
      end else begin
         sync <= {sync[1:0], d};
      end
   end

   assign q = sync[2];

endmodule

// File: rtl/p_cdc_req_xmit.sv
// Four-phase req/ack CDC transmitter fed by a small FIFO; optional CDC_XMIT_TIMEOUT_EN adds a sticky REQ timeout.
// Latency: a word pushed at edge N raises xreq after edge N+1 when idle.
// Backpressure: src_ready drops when the FIFO is full; a pop frees space one cycle later.
module p_cdc_req_xmit
   import p_cdc_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DFLT,
   parameter int DEPTH   = DEPTH_DFLT,
   parameter int TIMEOUT = TIMEOUT_DFLT
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_data,
   output logic             xreq,
   output logic [WIDTH-1:0] xdata,
   input  logic             xack,
   output logic             busy,
   output logic             err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_X = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp;
   logic [AW:0]      rp;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             ack_s;
   state_t           state;
   state_t           state_nxt;

   p_SSYNC3DO_C_PPP u_ack_sync (
      .clk  (clk),
      .clr_ (reset_),
      .d    (xack),
      .q    (ack_s)
   );

   assign full      = (wp ^ rp) == FULL_X;
   assign empty     = (wp == rp);
   assign src_ready = !full;
   assign push      = src_valid && !full;
   assign busy      = !empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp[AW-1:0]] <= src_data;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A stale ack_s seen in IDLE blocks the next request until it clears.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty && !ack_s) state_nxt = REQ;
         REQ:     if (ack_s)            state_nxt = DROP;
         DROP:    if (!ack_s)           state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop = (state == IDLE) && (state_nxt == REQ);
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         xreq  <= 1'b0;
         xdata <= '0;
      end else begin
         xreq <= (state_nxt == REQ);
         if (pop) xdata <= mem[rp[AW-1:0]];
      end
   end

`ifdef CDC_XMIT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] to_cnt;
   logic          err_q;

   // Counter saturates at TIMEOUT; the flag sets on the edge that reaches it.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (pop) begin
            to_cnt <= '0;
         end else if ((state == REQ) && (to_cnt != TW'(TIMEOUT))) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if ((state == REQ) && (to_cnt == TW'(TIMEOUT - 1))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_timeout = err_q;
`else
   logic to_unused;
   assign to_unused   = (TIMEOUT != 0);
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_p_cdc_req_xmit.sv
// Bench for p_cdc_req_xmit: directed scenarios plus random bursts, checked against
// a queue-based delivery model and an occupancy count derived from pushes and request rises.
module tb_p_cdc_req_xmit;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 255;
`ifdef CDC_XMIT_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   logic             clk;
   logic             reset_;
   logic             src_valid;
   logic             src_ready;
   logic [WIDTH-1:0] src_data;
   logic             xreq;
   logic [WIDTH-1:0] xdata;
   logic             xack;
   logic             busy;
   logic             err_timeout;

   logic             ack_mode;
   logic             ack_force;
   int               lb_dly;
   logic [7:0]       sr;

   int               checks = 0;
   int               errors = 0;

   logic [WIDTH-1:0] exp_q[$];
   int               n_push = 0;
   int               n_pop  = 0;
   int               occ    = 0;
   logic             last_acc = 1'b0;
   logic             saw_not_ready = 1'b0;
   logic [WIDTH-1:0] held = '0;
   logic             prev_xreq = 1'b0;

   p_cdc_req_xmit #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset_      (reset_),
      .src_valid   (src_valid),
      .src_ready   (src_ready),
      .src_data    (src_data),
      .xreq        (xreq),
      .xdata       (xdata),
      .xack        (xack),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Destination stand-in: xreq delayed by lb_dly edges, or a forced level.
   always @(posedge clk or negedge reset_) begin
      if (!reset_) sr <= 8'h00;
      else         sr <= {sr[6:0], xreq};
   end
   assign xack = ack_mode ? sr[lb_dly-1] : ack_force;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Acceptance follows the model's occupancy, not the DUT's src_ready.
   initial forever begin
      @(posedge clk);
      if (reset_ && src_valid && (occ < DEPTH)) begin
         exp_q.push_back(src_data);
         n_push++;
         last_acc = 1'b1;
      end else begin
         last_acc = 1'b0;
      end
   end

   // Each xreq rise delivers the oldest queued word; xdata holds between rises.
   initial forever begin
      @(negedge clk);
      if (!reset_) begin
         prev_xreq = 1'b0;
         held      = '0;
      end else begin
         if (xreq && !prev_xreq) begin
            n_pop++;
            if (exp_q.size() == 0) begin
               chk("spurious_req", 32'd1, 32'd0);
            end else begin
               chk("order", xdata, exp_q.pop_front());
            end
            held = xdata;
         end else begin
            chk("xdata_stable", xdata, held);
         end
         occ = n_push - n_pop;
         chk("src_ready", src_ready, (occ < DEPTH));
         if (occ > 0 || xreq) chk("busy_active", busy, 1);
         if (!src_ready) saw_not_ready = 1'b1;
         prev_xreq = xreq;
      end
   end

   task automatic push(input logic [WIDTH-1:0] d);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      #1;
      src_valid = 1'b1;
      src_data  = d;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (last_acc) begin
            ok = 1'b1;
            break;
         end
      end
      src_valid = 1'b0;
      if (!ok) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_xreq(input int budget, input logic lvl, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (xreq === lvl) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, ok, 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && !xreq && !xack && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, ok, 1);
   endtask

   task automatic do_reset(input logic ack_lvl);
      @(negedge clk);
      #1;
      reset_    = 1'b0;
      ack_mode  = 1'b0;
      ack_force = ack_lvl;
      exp_q.delete();
      n_push = 0;
      n_pop  = 0;
      occ    = 0;
      repeat (2) @(negedge clk);
      #1;
      reset_ = 1'b1;
   endtask

   initial begin
      int base;
      logic any_req;
      reset_    = 1'b0;
      src_valid = 1'b0;
      src_data  = '0;
      ack_mode  = 1'b1;
      ack_force = 1'b0;
      lb_dly    = 2;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_xreq", xreq, 0);
      chk("rst_xdata", xdata, 0);
      chk("rst_src_ready", src_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_timeout, 0);
      #1;
      reset_ = 1'b1;

      // 1: single word over a 2-cycle loopback
      push(8'hA5);
      @(negedge clk);
      chk("t1_xreq_edge_n", xreq, 0);
      @(negedge clk);
      chk("t1_xreq_edge_n1", xreq, 1);
      chk("t1_xdata", xdata, 8'hA5);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (xack) begin
               seen = 1'b1;
               break;
            end
         end
         chk("t1_xack_seen", seen, 1);
      end
      repeat (3) @(negedge clk);
      chk("t1_xreq_hold", xreq, 1);
      @(negedge clk);
      chk("t1_xreq_fall", xreq, 0);
      chk("t1_busy_drop_wait", busy, 1);
      wait_idle(40, "t1_idle");

      // 2: six back-to-back words into a 4-deep FIFO
      base = n_pop;
      saw_not_ready = 1'b0;
      for (int i = 1; i <= 6; i++) push(WIDTH'(i));
      wait_idle(300, "t2_idle");
      chk("t2_full_seen", saw_not_ready, 1);
      chk("t2_delivered", n_pop - base, 6);

      // 3: ack held low
      ack_mode  = 1'b0;
      ack_force = 1'b0;
      push(8'h5A);
      wait_xreq(10, 1'b1, "t3_req");
      repeat (TIMEOUT - 1) @(negedge clk);
      chk("t3_err_before", err_timeout, 0);
      chk("t3_xreq_held", xreq, 1);
      chk("t3_xdata_held", xdata, 8'h5A);
      @(negedge clk);
      chk("t3_err_at_timeout", err_timeout, TO_EN);
      #1;
      ack_force = 1'b1;
      wait_xreq(20, 1'b0, "t3_xreq_drop");
      #1;
      ack_force = 1'b0;
      wait_idle(40, "t3_idle");
      chk("t3_err_sticky", err_timeout, TO_EN);

      // 4: reset mid-REQ
      push(8'h11);
      push(8'h22);
      wait_xreq(10, 1'b1, "t4_req");
      #1;
      reset_ = 1'b0;
      #1;
      chk("t4_xreq_async", xreq, 0);
      chk("t4_busy_async", busy, 0);
      chk("t4_ready_async", src_ready, 1);
      chk("t4_err_cleared", err_timeout, 0);
      exp_q.delete();
      n_push = 0;
      n_pop  = 0;
      occ    = 0;
      @(negedge clk);
      #1;
      reset_   = 1'b1;
      ack_mode = 1'b1;
      push(8'h77);
      @(negedge clk);
      @(negedge clk);
      chk("t4_restart_xreq", xreq, 1);
      chk("t4_restart_xdata", xdata, 8'h77);
      wait_idle(40, "t4_idle");

      // 5: ack high across reset release
      do_reset(1'b1);
      repeat (6) @(negedge clk);
      push(8'h3C);
      any_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (xreq) any_req = 1'b1;
      end
      chk("t5_no_req_stale_ack", any_req, 0);
      chk("t5_busy_pending", busy, 1);
      #1;
      ack_force = 1'b0;
      wait_xreq(20, 1'b1, "t5_req");
      chk("t5_xdata", xdata, 8'h3C);
      ack_mode = 1'b1;
      wait_idle(40, "t5_idle");

      // 6: push and pop on the same edge with 3 entries queued
      ack_mode  = 1'b0;
      ack_force = 1'b0;
      push(8'h40);
      wait_xreq(10, 1'b1, "t6_req");
      push(8'h41);
      push(8'h42);
      push(8'h43);
      @(negedge clk);
      #1;
      ack_force = 1'b1;
      wait_xreq(20, 1'b0, "t6_drop");
      #1;
      ack_force = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      src_valid = 1'b1;
      src_data  = 8'h44;
      @(posedge clk);
      #1;
      src_valid = 1'b0;
      @(negedge clk);
      chk("t6_pop_edge", xreq, 1);
      chk("t6_pop_data", xdata, 8'h41);
      chk("t6_count3_ready", src_ready, 1);
      push(8'h45);
      @(negedge clk);
      chk("t6_count4_full", src_ready, 0);
      ack_mode = 1'b1;
      base = n_pop;
      wait_idle(300, "t6_idle");
      chk("t6_drained", n_pop - base, 4);

      // Random bursts with varying loopback delay
      for (int r = 0; r < 3; r++) begin
         lb_dly = $urandom_range(1, 4);
         base = n_push;
         for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(WIDTH'($urandom));
         end
         wait_idle(400, "rnd_idle");
         chk("rnd_pushed", n_push - base, 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
